// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-slot shared-ALU arbiter.
// Holds operand/tag widths, aluOp and func encodings, flag bit positions,
// the issue-register payload struct and the op decoder used by the ALU core.
package alu_share_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  // aluOp encodings
  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_FUNC = 1'b1;

  // func codes, meaningful only when aluOp = OP_FUNC
  localparam logic [4:0] F_SUB = 5'b00101;
  localparam logic [4:0] F_SHR = 5'b01001;
  localparam logic [4:0] F_NOT = 5'b00110;

  // Bit positions inside the 4-bit {carry, overflow, zero, neg} flag word
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SHR,
    ALU_NOT,
    ALU_ILL
  } alu_kind_e;

  // Payload captured in the issue register
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              op;
    logic [4:0]        func;
    logic [TAG_W-1:0]  tag;
    logic              slot;
  } issue_t;

  function automatic alu_kind_e decode_op(input logic op, input logic [4:0] func);
    alu_kind_e kind;
    kind = ALU_ILL;
    if (op == OP_ADD) begin
      kind = ALU_ADD;
    end else begin
      case (func)
        F_SUB:   kind = ALU_SUB;
        F_SHR:   kind = ALU_SHR;
        F_NOT:   kind = ALU_NOT;
        default: kind = ALU_ILL;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU core shared by both issue slots.
// Ports:
//   a, b      in   operands aluIn1 / aluIn2
//   op, func  in   aluOp and func select
//   carry_in  in   borrow for SUB (result = b - a - carry_in)
//   result    out  ALU result (0 for an illegal func)
//   flags     out  {carry, overflow, zero, neg}; all 0 for an illegal func
//   illegal   out  unsupported func with aluOp = OP_FUNC
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  input  logic [4:0]        func,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              illegal
);

  localparam int MSB = DATA_W - 1;

  alu_kind_e kind;
  logic      ovf;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    kind    = decode_op(op, func);
    result  = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    flags   = '0;

    case (kind)
      ALU_ADD: begin
        result = a + b;
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        result = b - a - DATA_W'(carry_in);
        // Subtrahend is a, so overflow is judged against the sign of b
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
      end
      ALU_SHR: begin
        // Any shift amount of 32 or more flushes every bit out
        result = (|a[MSB:5]) ? '0 : (b >> a[4:0]);
      end
      ALU_NOT: begin
        result = ~b;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    if (!illegal) begin
      flags[FLAG_C] = (!a[MSB] &&  b[MSB] && !result[MSB]) ||
                      ( a[MSB] && !b[MSB] && !result[MSB]) ||
                      ( a[MSB] &&  b[MSB]);
      flags[FLAG_V] = ovf;
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[MSB];
    end
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with grant enable.
// Ports:
//   clk, reset  in   clock, synchronous active-high reset (pointer -> slot 0)
//   en          in   a grant may be issued this cycle
//   req         in   request vector, bit i = requester i
//   gnt         out  one-hot grant (or 0), combinational from req/en/pointer
// After any grant the pointer moves to the requester that was not granted.
module alu_share_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      if (req == 2'b11) begin
        gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
      if (gnt != 2'b00) begin
        ptr_d = ~gnt[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between two VLIW integer issue slots.
// Round-robin arbitration picks at most one request per cycle into the issue
// register (s1); the ALU result is captured in the response register (s2),
// which drives the single response channel tagged with slot id and tag.
// A per-slot carry register feeds the SUB borrow input.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready [1:0]  per-slot handshake, bit i = slot i
//   req_a*/req_b*              operands aluIn1 / aluIn2 per slot
//   req_op [1:0]               aluOp per slot
//   req_func*/req_tag*         func and tag per slot
//   rsp_valid/rsp_ready        response handshake
//   rsp_slot/rsp_tag           origin of the response
//   rsp_data/rsp_flags         ALU result and {carry, overflow, zero, neg}
//   rsp_illegal                unsupported func on aluOp = 1
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int TW = TAG_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req_a0,
  input  logic [DW-1:0] req_a1,
  input  logic [DW-1:0] req_b0,
  input  logic [DW-1:0] req_b1,
  input  logic [1:0]    req_op,
  input  logic [4:0]    req_func0,
  input  logic [4:0]    req_func1,
  input  logic [TW-1:0] req_tag0,
  input  logic [TW-1:0] req_tag1,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_slot,
  output logic [TW-1:0] rsp_tag,
  output logic [DW-1:0] rsp_data,
  output logic [3:0]    rsp_flags,
  output logic          rsp_illegal
);

  logic       advance;   // s2 loads, s1 moves forward
  logic       accept;    // issue register can take a new op
  logic [1:0] gnt;

  logic       s1_valid_q, s1_valid_d;
  issue_t     s1_q, s1_d;

  logic          s2_valid_q, s2_valid_d;
  logic          rsp_slot_q, rsp_slot_d;
  logic [TW-1:0] rsp_tag_q, rsp_tag_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]    rsp_flags_q, rsp_flags_d;
  logic          rsp_illegal_q, rsp_illegal_d;

  logic [1:0] carry_q, carry_d;

  logic [DW-1:0] alu_result;
  logic [3:0]    alu_flags;
  logic          alu_illegal;
  logic          alu_carry_in;

  assign advance = !s2_valid_q || rsp_ready;
  assign accept  = !s1_valid_q || advance;

  alu_share_arbiter_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (accept && !reset),
    .req   (req_valid),
    .gnt   (gnt)
  );

  // The grant itself is the ready: a slot is accepted exactly when granted
  assign req_ready = gnt;

  // Issue stage
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (accept) begin
      s1_valid_d = |gnt;
      if (gnt[1]) begin
        s1_d.a    = req_a1;
        s1_d.b    = req_b1;
        s1_d.op   = req_op[1];
        s1_d.func = req_func1;
        s1_d.tag  = req_tag1;
        s1_d.slot = 1'b1;
      end else if (gnt[0]) begin
        s1_d.a    = req_a0;
        s1_d.b    = req_b0;
        s1_d.op   = req_op[0];
        s1_d.func = req_func0;
        s1_d.tag  = req_tag0;
        s1_d.slot = 1'b0;
      end
    end
  end

  // Carry is read from the current s1 slot; it is written on the same edge
  // that moves the op to s2, so a back-to-back op on that slot sees it.
  assign alu_carry_in = carry_q[s1_q.slot];

  alu_share_arbiter_alu u_alu (
    .a        (s1_q.a),
    .b        (s1_q.b),
    .op       (s1_q.op),
    .func     (s1_q.func),
    .carry_in (alu_carry_in),
    .result   (alu_result),
    .flags    (alu_flags),
    .illegal  (alu_illegal)
  );

  // Result stage and carry update
  always_comb begin
    s2_valid_d    = s2_valid_q;
    rsp_slot_d    = rsp_slot_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_data_d    = rsp_data_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_illegal_d = rsp_illegal_q;
    carry_d       = carry_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_slot_d    = s1_q.slot;
        rsp_tag_d     = s1_q.tag;
        rsp_data_d    = alu_result;
        rsp_flags_d   = alu_flags;
        rsp_illegal_d = alu_illegal;
        if (!alu_illegal) begin
          carry_d[s1_q.slot] = alu_flags[FLAG_C];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      rsp_slot_q    <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_data_q    <= '0;
      rsp_flags_q   <= '0;
      rsp_illegal_q <= 1'b0;
      carry_q       <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s2_valid_q    <= s2_valid_d;
      rsp_slot_q    <= rsp_slot_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_data_q    <= rsp_data_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_illegal_q <= rsp_illegal_d;
      carry_q       <= carry_d;
    end
  end

  // NOTE: the issue payload carries no reset; it is only ever observed while
  // s1_valid_q is set, so clearing it would cost reset fan-out for nothing.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign rsp_valid   = s2_valid_q;
  assign rsp_slot    = rsp_slot_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 time unit later, well away from the next edge.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]  req_op;
  logic [4:0]  req_func0, req_func1;
  logic [3:0]  req_tag0, req_tag1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_slot;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [4:0] SUB = 5'b00101;
  localparam logic [4:0] SHR = 5'b01001;
  localparam logic [4:0] NOT = 5'b00110;
  localparam logic [4:0] BAD = 5'b11111;

  typedef struct packed {
    logic        slot;
    logic        op;
    logic [4:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] d;    // expected rsp_data
    logic [3:0]  f;    // expected {c, v, z, n}
    logic        ill;  // expected rsp_illegal
  } vec_t;

  vec_t seq[$];

  alu_share_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a0      (req_a0),
    .req_a1      (req_a1),
    .req_b0      (req_b0),
    .req_b1      (req_b1),
    .req_op      (req_op),
    .req_func0   (req_func0),
    .req_func1   (req_func1),
    .req_tag0    (req_tag0),
    .req_tag1    (req_tag1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_slot    (rsp_slot),
    .rsp_tag     (rsp_tag),
    .rsp_data    (rsp_data),
    .rsp_flags   (rsp_flags),
    .rsp_illegal (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic slot, input logic op, input logic [4:0] func,
                              input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                              input logic [31:0] d, input logic [3:0] f, input logic ill);
    vec_t v;
    v.slot = slot; v.op = op; v.func = func; v.a = a; v.b = b; v.tag = tag;
    v.d = d; v.f = f; v.ill = ill;
    return v;
  endfunction

  task automatic drive_slot(input vec_t v);
    if (v.slot) begin
      req_a1 = v.a; req_b1 = v.b; req_func1 = v.func; req_tag1 = v.tag;
      req_op[1] = v.op; req_valid = 2'b10;
    end else begin
      req_a0 = v.a; req_b0 = v.b; req_func0 = v.func; req_tag0 = v.tag;
      req_op[0] = v.op; req_valid = 2'b01;
    end
  endtask

  task automatic check_rsp(input string tag, input logic slot, input logic [3:0] t,
                           input logic [31:0] d, input logic [3:0] f, input logic ill);
    check({tag, ".valid"}, rsp_valid, 1'b1);
    check({tag, ".slot"}, rsp_slot, slot);
    check({tag, ".tag"}, rsp_tag, t);
    check({tag, ".data"}, rsp_data, d);
    check({tag, ".flags"}, rsp_flags, f);
    check({tag, ".illegal"}, rsp_illegal, ill);
  endtask

  // One op per cycle from the queued vectors, rsp_ready held high; each
  // response is expected exactly two cycles after its request is presented.
  task automatic run_seq(input string name);
    int n;
    n = seq.size();
    for (int c = 0; c < n + 2; c++) begin
      req_valid = 2'b00;
      if (c < n) drive_slot(seq[c]);
      #1;
      if (c < n)
        check($sformatf("%s[%0d].ready", name, c), req_ready, seq[c].slot ? 2'b10 : 2'b01);
      if (c >= 2)
        check_rsp($sformatf("%s[%0d]", name, c - 2), seq[c-2].slot, seq[c-2].tag,
                  seq[c-2].d, seq[c-2].f, seq[c-2].ill);
      else
        check($sformatf("%s.early_valid%0d", name, c), rsp_valid, 1'b0);
      tick();
    end
    req_valid = 2'b00;
    seq.delete();
  endtask

  logic alt_slot [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1; rsp_ready = 1'b1; req_valid = 2'b00; req_op = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    req_func0 = '0; req_func1 = '0; req_tag0 = '0; req_tag1 = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    #1;
    check("rst.valid", rsp_valid, 1'b0);
    check("rst.slot", rsp_slot, 1'b0);
    check("rst.tag", rsp_tag, 4'h0);
    check("rst.data", rsp_data, 32'h0);
    check("rst.flags", rsp_flags, 4'h0);
    check("rst.illegal", rsp_illegal, 1'b0);
    check("rst.ready", req_ready, 2'b00);
    tick();

    // Signed overflow on ADD, two-cycle latency. Pointer then moves to slot 1.
    seq.push_back(mk(1'b0, 1'b0, 5'd0, 32'h7FFF_FFFF, 32'h1, 4'd3, 32'h8000_0000, 4'b0101, 1'b0));
    run_seq("add_ovf");

    // Both slots valid every cycle: grants alternate starting at slot 1
    req_op = 2'b00;
    req_a0 = 32'd10;  req_b0 = 32'd20; req_func0 = 5'd0; req_tag0 = 4'd5;
    req_a1 = 32'd100; req_b1 = 32'd1;  req_func1 = 5'd0; req_tag1 = 4'd9;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 2'b11 : 2'b00;
      #1;
      if (c < 4)
        check($sformatf("alt[%0d].ready", c), req_ready, alt_slot[c] ? 2'b10 : 2'b01);
      if (c >= 2)
        check_rsp($sformatf("alt[%0d]", c - 2), alt_slot[c-2], alt_slot[c-2] ? 4'd9 : 4'd5,
                  alt_slot[c-2] ? 32'd101 : 32'd30, 4'b0000, 1'b0);
      tick();
    end

    // Carry chaining, per-slot independence, illegal func, SHR/NOT/ADD flags.
    // Both carries are 0 here.
    seq.push_back(mk(1'b1, 1'b1, SUB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'h0,         4'b1010, 1'b0));
    seq.push_back(mk(1'b0, 1'b1, SUB, 32'h1,         32'h5,         4'd2, 32'h4,         4'b0000, 1'b0));
    seq.push_back(mk(1'b1, 1'b1, SUB, 32'h1,         32'h5,         4'd3, 32'h3,         4'b0000, 1'b0));
    seq.push_back(mk(1'b1, 1'b1, SUB, 32'h1,         32'h5,         4'd4, 32'h4,         4'b0000, 1'b0));
    seq.push_back(mk(1'b0, 1'b1, SUB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'h0,         4'b1010, 1'b0));
    seq.push_back(mk(1'b0, 1'b1, BAD, 32'h1,         32'h5,         4'd6, 32'h0,         4'b0000, 1'b1));
    seq.push_back(mk(1'b0, 1'b1, SUB, 32'h1,         32'h5,         4'd7, 32'h3,         4'b0000, 1'b0));
    seq.push_back(mk(1'b1, 1'b1, SHR, 32'd4,         32'h8000_0000, 4'd8, 32'h0800_0000, 4'b1000, 1'b0));
    seq.push_back(mk(1'b1, 1'b1, SHR, 32'd32,        32'hFFFF_FFFF, 4'd9, 32'h0,         4'b1010, 1'b0));
    seq.push_back(mk(1'b1, 1'b1, NOT, 32'h0,         32'h0,         4'd10, 32'hFFFF_FFFF, 4'b0001, 1'b0));
    seq.push_back(mk(1'b0, 1'b0, 5'd0, 32'h8000_0000, 32'h8000_0000, 4'd11, 32'h0,       4'b1110, 1'b0));
    seq.push_back(mk(1'b0, 1'b1, SUB, 32'h0,         32'h0,         4'd12, 32'hFFFF_FFFF, 4'b0001, 1'b0));
    seq.push_back(mk(1'b1, 1'b1, SUB, 32'h1,         32'h8000_0000, 4'd13, 32'h7FFF_FFFF, 4'b1100, 1'b0));
    seq.push_back(mk(1'b0, 1'b1, SHR, 32'hFFFF_FFFF, 32'h1,         4'd14, 32'h0,         4'b1010, 1'b0));
    run_seq("ops");

    // Backpressure: rsp_ready low for 5 cycles, both slots requesting.
    // Pointer is at slot 1.
    rsp_ready = 1'b0;
    req_op = 2'b00;
    req_a1 = 32'd1; req_b1 = 32'd2; req_func1 = 5'd0; req_tag1 = 4'd14;
    req_a0 = 32'd3; req_b0 = 32'd4; req_func0 = 5'd0; req_tag0 = 4'd15;
    req_valid = 2'b11;
    #1;
    check("bp.grant0", req_ready, 2'b10);
    tick();
    #1;
    check("bp.grant1", req_ready, 2'b01);
    check("bp.empty", rsp_valid, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp.hold%0d.ready", k), req_ready, 2'b00);
      check_rsp($sformatf("bp.hold%0d", k), 1'b1, 4'd14, 32'd3, 4'b0000, 1'b0);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    #1;
    check_rsp("bp.drain0", 1'b1, 4'd14, 32'd3, 4'b0000, 1'b0);
    tick();
    #1;
    check_rsp("bp.drain1", 1'b0, 4'd15, 32'd7, 4'b0000, 1'b0);
    tick();
    #1;
    check("bp.no_dup", rsp_valid, 1'b0);
    tick();

    // Reset with two ops in flight. Slot 1 op sets carry[1] before reset.
    // Pointer is at slot 1.
    req_op = 2'b11;
    req_a1 = 32'hFFFF_FFFF; req_b1 = 32'hFFFF_FFFF; req_func1 = SUB; req_tag1 = 4'd2;
    req_a0 = 32'hFFFF_FFFF; req_b0 = 32'hFFFF_FFFF; req_func0 = SUB; req_tag0 = 4'd1;
    req_valid = 2'b11;
    #1;
    check("mrst.grant0", req_ready, 2'b10);
    tick();
    #1;
    check("mrst.grant1", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_a0 = 32'h1; req_b0 = 32'h5; req_tag0 = 4'd6;
    req_a1 = 32'h1; req_b1 = 32'h5; req_tag1 = 4'd7;
    req_valid = 2'b11;
    #1;
    check("mrst.valid", rsp_valid, 1'b0);
    check("mrst.tag", rsp_tag, 4'h0);
    check("mrst.flags", rsp_flags, 4'h0);
    check("mrst.ptr", req_ready, 2'b01);
    tick();
    #1;
    check("mrst.ready2", req_ready, 2'b10);
    check("mrst.no_stale", rsp_valid, 1'b0);
    tick();
    req_valid = 2'b00;
    #1;
    check_rsp("mrst.s0", 1'b0, 4'd6, 32'd4, 4'b0000, 1'b0);
    tick();
    #1;
    check_rsp("mrst.s1", 1'b1, 4'd7, 32'd4, 4'b0000, 1'b0);
    tick();
    #1;
    check("mrst.idle", rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU core between the two VLIW integer issue slots.
- Round-robin arbitration with valid/ready handshake on each request port.
- Two-stage pipeline: issue register, then ALU-result register. One shared response channel tagged with the slot id.
- Holds a per-slot carry register that feeds the ALU borrow input for chained subtract-with-borrow.

Parameters:
- DW, 32, operand/result width (fixed 32 for the ALU core)
- TW, 4, request tag width, returned unchanged in the response

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-slot request valid (bit i = slot i)
- req_ready  out  2  per-slot request ready
- req_a0, req_a1  in  32 each  operand aluIn1 for slot 0/1
- req_b0, req_b1  in  32 each  operand aluIn2 for slot 0/1
- req_op  in  2  aluOp per slot
- req_func0, req_func1  in  5 each  func per slot
- req_tag0, req_tag1  in  TW each  tag per slot
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_slot  out  1  originating slot
- rsp_tag  out  TW  originating tag
- rsp_data  out  32  ALU result
- rsp_flags  out  4  {carry, overflow, zero, neg}
- rsp_illegal  out  1  unsupported func on aluOp=1

Behaviour:
- Reset (synchronous): all of the following clear to 0 and the RR pointer resets to slot 0:
  - s1_valid, s2_valid, rsp_valid, rsp_slot, rsp_tag, rsp_data, rsp_flags, rsp_illegal
  - both carry registers
- Reset mid-operation discards in-flight operations; no response is produced for them.
- Ops:
  - aluOp=0: ADD, result = A+B.
  - aluOp=1, func 5'b00101: SUB, result = B-A-carry[slot].
  - aluOp=1, func 5'b01001: SHR, result = B>>A, logical; A>=32 gives 0.
  - aluOp=1, func 5'b00110: NOT, result = ~B.
  - aluOp=1, any other func: result 0, flags 0, rsp_illegal=1, carry[slot] unchanged.
- Flags:
  - overflow: signed add/sub rule.
  - zero: result==0.
  - neg: result[31].
  - carry = (A31=0 & B31=1 & R31=0) | (A31=1 & B31=0 & R31=0) | (A31=1 & B31=1).
- Arbitration:
  - At most one grant per cycle, and only when the issue stage can accept.
  - Both valid: grant the slot the RR pointer selects, then move the pointer to the other slot.
  - Only one valid: grant it; the pointer moves to the other slot.
  - req_ready[i]=1 only for the granted slot in that cycle. This is combinational from req_valid and the stall state.
- Pipeline:
  - s2 loads when !s2_valid or rsp_ready.
  - s1 advances into s2 under the same condition.
  - The issue stage accepts when !s1_valid or s1 is advancing.
  - Latency: request accepted in cycle N gives rsp_valid in cycle N+2 with no backpressure.
  - Throughput: 1 op per cycle.
- Carry register: carry[slot] updates from the ALU carry output when that slot's op moves s1->s2, ADD/SUB/SHR/NOT all included. A back-to-back SUB from the same slot therefore sees the updated carry with no bubble.
- Backpressure: while rsp_valid=1 and rsp_ready=0, the response outputs hold stable, s1 holds, and no new grant is issued.
- Simultaneous s2 drain and s1 advance in the same cycle is legal. No slot is granted twice in a cycle.

Decomposition:
- Shared package holds:
  - op encodings: OP_ADD=1'b0, OP_FUNC=1'b1
  - func codes: F_SUB=5'b00101, F_SHR=5'b01001, F_NOT=5'b00110
  - flag bit indices, and the issue-register struct {a, b, op, func, tag, slot}
- Natural sub-module: rr_arb2, a 2-requester round-robin with grant-enable and pointer update.
- The ALU core is instantiated as an existing combinational unit.

Test Plan:
- Slot 0 ADD A=0x7FFFFFFF, B=1, tag=3 -> 2 cycles later: rsp_data=0x80000000, flags {c0, ov1, z0, n1}, rsp_slot=0, rsp_tag=3.
- Both slots valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1. No starvation; one response per cycle in grant order.
- Slot 1 SUB A=B=0xFFFFFFFF with carry 0 -> data 0, carry=1, zero=1. The next-cycle slot 1 SUB A=1, B=5 -> data 3. A slot 0 SUB A=1, B=5 in between -> data 4, since slot 0's carry is independent.
- Slot 0 op=1, func=5'b11111 -> rsp_illegal=1, data 0, flags 0. A following SUB on slot 0 uses the unchanged carry.
- Hold rsp_ready=0 for 5 cycles with both slots requesting:
  - response outputs stable; exactly 2 ops in flight; req_ready=0 after that.
  - on release, remaining ops drain in order with no loss or duplication.
- Assert reset for 1 cycle with 2 ops in flight -> next cycle rsp_valid=0, carries 0, pointer at slot 0. No stale response appears.
